// File: rtl/hamming_sec_encoder_stream_pkg.sv
// Shared constants and types for the streaming Hamming SEC encoder.
package hamming_sec_encoder_stream_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;
  localparam int PAR_W  = 4;

  // Codeword positions of the parity bits (one-hot positions 1,2,4,8 in 1-based terms).
  localparam int PAR_IDX [PAR_W] = '{0, 1, 3, 7};

  // Codeword position of each data bit d0..d7.
  localparam int DATA_IDX [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/hamming_sec_encode_comb.sv
// Pure combinational 8-bit -> 12-bit Hamming SEC encoder.
module hamming_sec_encode_comb
  import hamming_sec_encoder_stream_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);

  // Scatter data bits, then each parity bit covers every position whose
  // 1-based index shares its one-hot bit.
  always_comb begin
    code = '0;
    for (int i = 0; i < DATA_W; i++) code[DATA_IDX[i]] = data[i];
    for (int k = 0; k < PAR_W; k++) begin
      for (int j = 0; j < CODE_W; j++) begin
        if ((j != PAR_IDX[k]) && (((j + 1) & (PAR_IDX[k] + 1)) != 0))
          code[PAR_IDX[k]] = code[PAR_IDX[k]] ^ code[j];
      end
    end
  end

endmodule

// File: rtl/hamming_sec_encoder_stream.sv
// Streaming Hamming SEC encoder with 2-entry skid buffer, one-shot error
// injection and a delivered-word counter.
module hamming_sec_encoder_stream
  import hamming_sec_encoder_stream_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_injected,
  input  logic              inj_arm,
  input  logic [3:0]        inj_pos,
  output logic              inj_pending,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  word_count
);

  buf_state_e        state, state_nxt;
  logic [CODE_W-1:0] enc_code, acc_code, main_code, skid_code;
  logic              acc_inj, main_inj, skid_inj;
  logic [3:0]        inj_pos_q;
  logic              accept, hs, load_main, load_skid;

  hamming_sec_encode_comb u_enc (
    .data (in_data),
    .code (enc_code)
  );

  assign accept       = in_valid & in_ready;
  assign hs           = out_valid & out_ready;
  assign out_valid    = (state != EMPTY);
  assign out_code     = main_code;
  assign out_injected = main_inj;

  // Out-of-range positions still consume the pending injection but flip nothing.
  assign acc_inj  = inj_pending && (inj_pos_q < 4'(CODE_W));
  assign acc_code = enc_code ^ (acc_inj ? (CODE_W'(1) << inj_pos_q) : '0);

  // Main reloads on first fill, on pass-through, or when the skid drains into it.
  assign load_main = ((state == EMPTY) && accept) ||
                     ((state == ONE) && accept && hs) ||
                     ((state == TWO) && hs);
  assign load_skid = (state == ONE) && accept && !hs;

  // Buffer occupancy next-state.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !hs)      state_nxt = TWO;
        else if (!accept && hs) state_nxt = EMPTY;
      end
      TWO:     if (hs) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // State register; in_ready is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
    end
  end

  // Main and skid data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_code <= '0;
      main_inj  <= 1'b0;
      skid_code <= '0;
      skid_inj  <= 1'b0;
    end else begin
      if (load_main) begin
        main_code <= (state == TWO) ? skid_code : acc_code;
        main_inj  <= (state == TWO) ? skid_inj  : acc_inj;
      end
      if (load_skid) begin
        skid_code <= acc_code;
        skid_inj  <= acc_inj;
      end
    end
  end

  // Injection arming: a coincident arm wins over consumption so it targets the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_pending <= 1'b0;
      inj_pos_q   <= '0;
    end else begin
      if (accept) inj_pending <= 1'b0;
      if (inj_arm) begin
        inj_pending <= 1'b1;
        inj_pos_q   <= inj_pos;
      end
    end
  end

  // Delivered-word counter; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         word_count <= '0;
    else if (clr_count) word_count <= '0;
    else if (hs)        word_count <= word_count + 1'b1;
  end

endmodule

// File: tb/tb_hamming_sec_encoder_stream.sv
// Directed bench for hamming_sec_encoder_stream.
module tb_hamming_sec_encoder_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [11:0] out_code;
  logic        out_injected;
  logic        inj_arm;
  logic [3:0]  inj_pos;
  logic        inj_pending;
  logic        clr_count;
  logic [15:0] word_count;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  hamming_sec_encoder_stream #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_injected (out_injected),
    .inj_arm      (inj_arm),
    .inj_pos      (inj_pos),
    .inj_pending  (inj_pending),
    .clr_count    (clr_count),
    .word_count   (word_count)
  );

  // Reference encoder written straight from the parity equations.
  function automatic logic [11:0] enc_model(input logic [7:0] d);
    logic [11:0] c;
    c = '0;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    c[8] = d[4]; c[9] = d[5]; c[10] = d[6]; c[11] = d[7];
    c[0] = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1] = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3] = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[7] = c[8] ^ c[9] ^ c[10] ^ c[11];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({in_ready, out_valid, out_code, out_injected, inj_pending, word_count} !==
        {1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b code=%h inj=%b pend=%b cnt=%0d want 1 0 000 0 0 0",
               in_ready, out_valid, out_code, out_injected, inj_pending, word_count);
    end
  endtask

  // Single accept with out_ready=1; checks 1-cycle latency then drain.
  task automatic send_one(input string name, input logic [7:0] d,
                          input logic [11:0] exp, input logic exp_inj);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s pre: out_valid=%b want 0", name, out_valid);
    end
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_code !== exp || out_injected !== exp_inj) begin
      errors++;
      $display("FAIL %s: vld=%b code=%h inj=%b want 1 %h %b", name, out_valid, out_code,
               out_injected, exp, exp_inj);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s drain: out_valid=%b want 0", name, out_valid);
    end
  endtask

  task automatic test_encode();
    out_ready = 1'b1;
    send_one("enc00", 8'h00, 12'h000, 1'b0);
    send_one("enc01", 8'h01, 12'h007, 1'b0);
    send_one("enc80", 8'h80, 12'h888, 1'b0);
    send_one("encFF", 8'hFF, 12'hF77, 1'b0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_code !== enc_model(8'(i)) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: vld=%b code=%h rdy=%b want 1 %h 1", i, out_valid, out_code,
                 in_ready, enc_model(8'(i)));
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (word_count !== 16'd256 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: cnt=%0d vld=%b want 256 0", word_count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; tick();
    vectors++;
    if (in_ready !== 1'b1 || out_code !== 12'h186) begin
      errors++; $display("FAIL bp_first: rdy=%b code=%h want 1 186", in_ready, out_code);
    end
    in_data = 8'h22; tick();
    in_data = 8'h33;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_code !== 12'h186) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rdy=%b vld=%b code=%h want 0 1 186", i, in_ready,
                 out_valid, out_code);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_code !== 12'h29B || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: vld=%b code=%h rdy=%b want 1 29b 1", out_valid, out_code, in_ready);
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_code !== 12'h31D) begin
      errors++; $display("FAIL bp_third: vld=%b code=%h want 1 31d", out_valid, out_code);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || word_count !== 16'd259) begin
      errors++; $display("FAIL bp_drain: vld=%b cnt=%0d want 0 259", out_valid, word_count);
    end
  endtask

  task automatic test_inject();
    out_ready = 1'b1;
    inj_arm = 1'b1; inj_pos = 4'd3; tick(); inj_arm = 1'b0;
    vectors++;
    if (inj_pending !== 1'b1) begin
      errors++; $display("FAIL inj_arm: pend=%b want 1", inj_pending);
    end
    in_valid = 1'b1; in_data = 8'hFF; tick();
    vectors++;
    if (out_code !== 12'hF7F || out_injected !== 1'b1 || inj_pending !== 1'b0) begin
      errors++;
      $display("FAIL inj_hit: code=%h inj=%b pend=%b want f7f 1 0", out_code, out_injected,
               inj_pending);
    end
    tick(); in_valid = 1'b0;
    vectors++;
    if (out_code !== 12'hF77 || out_injected !== 1'b0) begin
      errors++; $display("FAIL inj_next: code=%h inj=%b want f77 0", out_code, out_injected);
    end
    tick();
    // Out-of-range position consumes the arm without flipping.
    inj_arm = 1'b1; inj_pos = 4'd13; tick(); inj_arm = 1'b0;
    send_one("inj_pos13", 8'h80, 12'h888, 1'b0);
    vectors++;
    if (inj_pending !== 1'b0) begin
      errors++; $display("FAIL inj_pos13_pend: pend=%b want 0", inj_pending);
    end
    // Arm coincident with an accept targets the following word.
    in_valid = 1'b1; in_data = 8'h01; inj_arm = 1'b1; inj_pos = 4'd0;
    tick();
    in_valid = 1'b0; inj_arm = 1'b0;
    vectors++;
    if (out_code !== 12'h007 || out_injected !== 1'b0 || inj_pending !== 1'b1) begin
      errors++;
      $display("FAIL inj_coinc: code=%h inj=%b pend=%b want 007 0 1", out_code, out_injected,
               inj_pending);
    end
    tick();
    send_one("inj_coinc_next", 8'h01, 12'h006, 1'b1);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; tick();
    in_data = 8'hAA; inj_arm = 1'b1; inj_pos = 4'd5; tick();
    in_valid = 1'b0; inj_arm = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || inj_pending !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: rdy=%b pend=%b want 0 1", in_ready, inj_pending);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, in_ready, inj_pending, word_count, out_code, out_injected} !==
        {1'b0, 1'b1, 1'b0, 16'd0, 12'h000, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid: vld=%b rdy=%b pend=%b cnt=%0d code=%h inj=%b want 0 1 0 0 000 0",
               out_valid, in_ready, inj_pending, word_count, out_code, out_injected);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clr();
    out_ready = 1'b1;
    send_one("clr_pre", 8'h11, 12'h186, 1'b0);
    vectors++;
    if (word_count !== 16'd1) begin
      errors++; $display("FAIL clr_pre_cnt: cnt=%0d want 1", word_count);
    end
    in_valid = 1'b1; in_data = 8'h22; tick(); in_valid = 1'b0;
    clr_count = 1'b1; tick(); clr_count = 1'b0;
    vectors++;
    if (word_count !== 16'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_hs: cnt=%0d vld=%b want 0 0", word_count, out_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    inj_arm = 1'b0; inj_pos = '0; clr_count = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    test_reset();
    test_encode();
    test_back_to_back();
    test_backpressure();
    test_inject();
    test_reset_mid();
    test_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hamming_sec_encoder_stream.md
Name: hamming_sec_encoder_stream

Overview:
- Streaming Hamming SEC encoder on the memory write path: 8-bit data in, 12-bit codeword out, in the bit layout the SEC decoder consumes.
- Valid/ready on both sides; 2-entry skid buffer gives registered in_ready and full throughput.
- One-shot single-bit error injection so decoder-correction paths can be exercised in system.
- Counter of codewords delivered downstream.

Parameters:
CNT_W, 16, width of word_count (wraps).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data valid
in_ready  output  1  encoder can accept; registered
in_data  input  8  data word
out_valid  output  1  out_code valid
out_ready  input  1  downstream accepts
out_code  output  12  codeword
out_injected  output  1  sideband, qualified by out_valid: an error was injected into this codeword
inj_arm  input  1  pulse: arm injection for next accepted word
inj_pos  input  4  codeword bit index to flip, sampled with inj_arm
inj_pending  output  1  injection armed, not yet consumed
clr_count  input  1  synchronous clear of word_count
word_count  output  CNT_W  output handshakes since reset/clear

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: in_ready=1, out_valid=0, out_code=0, out_injected=0, inj_pending=0, word_count=0, both buffer entries empty.
- Accept = in_valid & in_ready. Output handshake = out_valid & out_ready.
- Encoding (combinational on in_data, registered at accept). Data mapping: d0→c[2], d1→c[4], d2→c[5], d3→c[6], d4→c[8], d5→c[9], d6→c[10], d7→c[11].
- Parity bits:
  - c[0] = c2^c4^c6^c8^c10
  - c[1] = c2^c5^c6^c9^c10
  - c[3] = c4^c5^c6^c11
  - c[7] = c8^c9^c10^c11
- Buffer FSM, states EMPTY, ONE, TWO. The main register drives out_code. The skid register holds overflow.
  - EMPTY: accept → ONE; out_valid rises the cycle after accept (latency 1).
  - ONE:
    - accept & handshake → ONE; main register reloads.
    - accept only → TWO; word goes to skid.
    - handshake only → EMPTY.
  - TWO: in_ready=0.
    - handshake → ONE; skid moves to main.
  - in_ready = (state != TWO), registered.
  - Sustained in_valid with out_ready=1 gives 1 word/cycle.
  - Words are never dropped, duplicated or reordered.
  - out_code and out_injected hold stable while out_valid & !out_ready.
- Injection:
  - inj_arm: inj_pending←1 and the 4-bit position latch ←inj_pos.
  - Re-arm while pending overwrites the position.
  - An accept with inj_pending=1 (registered value) XORs the codeword bit at the latched position.
    - That word's out_injected=1 and inj_pending clears.
    - Latched position ≥12: no bit flipped, out_injected=0, pending still consumed.
  - inj_arm in the same cycle as an accept: the injection applies to the next accepted word, not the current one; inj_pending=1 after that cycle.
- Counter:
  - word_count increments on each output handshake and wraps modulo 2^CNT_W.
  - clr_count has priority: clr_count & handshake in the same cycle → 0.
- Reset asserted mid-stream: all buffered words are discarded, outputs return to reset values immediately, and any armed injection is cancelled.

Decomposition:
- Shared package holds:
  - DATA_W=8, CODE_W=12
  - parity index constants {0,1,3,7}
  - data-to-codeword index map
  - buffer state typedef {EMPTY, ONE, TWO}
- Sub-module hamming_sec_encode_comb: pure combinational 8→12 encoder, reused by test models. All sequential logic stays in the top module.

Test Plan:
- Encode values, out_ready=1, single accepts: 0x00→0x000, 0x01→0x007, 0x80→0x888, 0xFF→0xF77. out_valid appears exactly 1 cycle after each accept; out_injected=0.
- Back-to-back 256 words 0x00..0xFF with out_ready=1: one output per cycle in order, in_ready stays 1, word_count=256.
- Backpressure: out_ready=0 while sending 0x11, 0x22, 0x33.
  - in_ready drops after 0x22 is accepted; 0x33 is held off.
  - out_code stays stable.
  - Releasing out_ready yields 0x11, 0x22, 0x33 codewords in order with no loss.
- Injection: inj_arm with inj_pos=3, then send 0xFF → out_code=0xF7F, out_injected=1, inj_pending clears. The next 0xFF gives 0xF77 with out_injected=0.
- Injection edges:
  - inj_pos=13 armed, then send 0x80 → 0x888, out_injected=0, pending cleared.
  - inj_arm coincident with an accept of 0x01 → that word is 0x007; the next word is flipped.
- rst_n low mid-transfer in state TWO → out_valid=0, in_ready=1, inj_pending=0, word_count=0 immediately. clr_count coincident with a handshake → word_count=0.
